// File: rtl/wb_byte_ram_slave_if.sv
// rtl/wb_byte_ram_slave_if.sv - Wishbone-style bus bundle between the memory controller and the byte-lane RAM slave
interface wb_byte_ram_slave_if #(
    parameter int WORD = 16
);
    localparam int ADR_W = WORD - (WORD / 8) + 1;

    logic             cyc_i;
    logic             stb_i;
    logic             we_i;
    logic [1:0]       sel_i;
    logic [ADR_W-1:0] adr_i;
    logic [WORD-1:0]  dat_i;
    logic [WORD-1:0]  dat_o;
    logic             ack_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/wb_byte_ram_slave.sv
// rtl/wb_byte_ram_slave.sv - single-port byte-lane RAM slave with programmable wait states and abort
module wb_byte_ram_slave #(
    parameter int WORD        = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    wb_byte_ram_slave_if.slave bus
);
    localparam int ADR_W = WORD - (WORD / 8) + 1;
    localparam int HALF  = WORD / 2;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t           state, state_nxt;
    logic [3:0]       wcnt, wcnt_nxt;
    logic             req;

    logic [ADR_W-1:0] adr_q;
    logic             we_q;
    logic [1:0]       sel_q;
    logic [WORD-1:0]  wdat_q;
    logic [WORD-1:0]  dat_q;

    logic [ADR_W-1:0] acc_adr;
    logic             acc_we;
    logic [1:0]       acc_sel;
    logic [WORD-1:0]  acc_dat;
    logic [WORD-1:0]  lane_mask;
    logic             in_range;
    logic             enter_ack;
    logic             mem_we;
    logic             ack;
    logic [WORD-1:0]  rd_word;

    logic [WORD-1:0]  mem [2**DEPTH_LOG2];

    assign req = bus.cyc_i & bus.stb_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT;
                        wcnt_nxt  = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                // Dropping cyc_i abandons the transfer even on the cycle that would have acked.
                if (!bus.cyc_i) begin
                    state_nxt = IDLE;
                end else if (wcnt == 4'd0) begin
                    state_nxt = ACK;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With zero wait states the access edge is the request edge, so the live bus is used instead of the latch.
    always_comb begin
        acc_adr   = (state == IDLE) ? bus.adr_i : adr_q;
        acc_we    = (state == IDLE) ? bus.we_i  : we_q;
        acc_sel   = (state == IDLE) ? bus.sel_i : sel_q;
        acc_dat   = (state == IDLE) ? bus.dat_i : wdat_q;
        lane_mask = {{HALF{acc_sel[1]}}, {HALF{acc_sel[0]}}};
        in_range  = (acc_adr >> DEPTH_LOG2) == '0;
        enter_ack = (state_nxt == ACK) && (state != ACK);
        mem_we    = enter_ack && acc_we && in_range && !rst_i;
        rd_word   = mem[acc_adr[DEPTH_LOG2-1:0]];
        ack       = (state == ACK);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adr_q  <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            wdat_q <= '0;
            dat_q  <= '0;
        end else begin
            if (state == IDLE && req) begin
                adr_q  <= bus.adr_i;
                we_q   <= bus.we_i;
                sel_q  <= bus.sel_i;
                wdat_q <= bus.dat_i;
            end
            if (enter_ack && !acc_we) begin
                dat_q <= in_range ? (rd_word & lane_mask) : '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            if (acc_sel[0]) mem[acc_adr[DEPTH_LOG2-1:0]][HALF-1:0]    <= acc_dat[HALF-1:0];
            if (acc_sel[1]) mem[acc_adr[DEPTH_LOG2-1:0]][WORD-1:HALF] <= acc_dat[WORD-1:HALF];
        end
    end

    assign bus.dat_o = dat_q;
    assign bus.ack_o = ack;
endmodule

// File: tb/tb_wb_byte_ram_slave.sv
// tb/tb_wb_byte_ram_slave.sv - randomized and directed bench for wb_byte_ram_slave across four wait-state settings
module tb_wb_byte_ram_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc_cnt = 0;
    int          total = 0;
    int          bad = 0;

    logic        cyc  [4];
    logic        stb  [4];
    logic        we   [4];
    logic [1:0]  sel  [4];
    logic [14:0] adr  [4];
    logic [15:0] wdat [4];
    logic        ack  [4];
    logic [15:0] rdat [4];

    logic [15:0] model [4][64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Instance k runs with ws_of(k) wait states.
    for (genvar g = 0; g < 4; g++) begin : gen_dut
        localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 15;
        wb_byte_ram_slave_if #(.WORD(16)) bus ();
        assign bus.cyc_i = cyc[g];
        assign bus.stb_i = stb[g];
        assign bus.we_i  = we[g];
        assign bus.sel_i = sel[g];
        assign bus.adr_i = adr[g];
        assign bus.dat_i = wdat[g];
        assign ack[g]    = bus.ack_o;
        assign rdat[g]   = bus.dat_o;
        wb_byte_ram_slave #(.WORD(16), .DEPTH_LOG2(10), .WAIT_STATES(WS)) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );
    end

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    function automatic logic [15:0] lanes(input logic [1:0] s);
        return {(s[1] ? 8'hFF : 8'h00), (s[0] ? 8'hFF : 8'h00)};
    endfunction

    function automatic logic [15:0] model_read(input int k, input logic [14:0] a, input logic [1:0] s);
        if (a >= 15'd1024) return 16'h0000;
        return model[k][a[5:0]] & lanes(s);
    endfunction

    task automatic model_write(input int k, input logic [14:0] a, input logic [1:0] s, input logic [15:0] d);
        if (a < 15'd1024)
            model[k][a[5:0]] = (model[k][a[5:0]] & ~lanes(s)) | (d & lanes(s));
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input int k, input logic w, input logic [1:0] s, input logic [14:0] a,
                        input logic [15:0] d, output logic [15:0] rd);
        int   lat;
        bit   got;
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; wdat[k] = d;
        lat = 0; got = 1'b0; rd = '0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ack[k]) begin
                got = 1'b1;
                rd  = rdat[k];
            end else begin
                // Anything presented after the request edge must be ignored.
                we[k] = 1'($urandom); sel[k] = 2'($urandom);
                adr[k] = 15'($urandom); wdat[k] = 16'($urandom);
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
        if (got) chk("latency", lat, ws_of(k) + 1);
        if (w) model_write(k, a, s, d);
        else   chk("rdata", 32'(rd), 32'(model_read(k, a, s)));
        @(posedge clk); #1;
        chk("ack_width", 32'(ack[k]), 32'd0);
        if (!w) chk("rd_hold", 32'(rdat[k]), 32'(rd));
    endtask

    task automatic watch_no_ack(input int k, input int n, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (ack[k]) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    task automatic b2b(input int k);
        int          last;
        int          n_ack;
        int          waited;
        bit          got;
        logic [15:0] wv;
        last = -1; n_ack = 0; wv = '0;
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            we[k]  = (i % 2 == 0);
            sel[k] = 2'b11;
            adr[k] = 15'(i / 2 + 1);
            if (i % 2 == 0) wv = 16'($urandom);
            wdat[k] = wv;
            waited = 0; got = 1'b0;
            while (!got && waited < 40) begin
                @(posedge clk); #1;
                waited++;
                if (ack[k]) got = 1'b1;
            end
            chk("b2b_ack", 32'(got), 32'd1);
            if (got) begin
                n_ack++;
                if (last >= 0) chk("b2b_gap", 32'(cyc_cnt - last >= ws_of(k) + 2), 32'd1);
                last = cyc_cnt;
                if (i % 2 == 0) model_write(k, 15'(i / 2 + 1), 2'b11, wv);
                else            chk("b2b_rdata", 32'(rdat[k]), 32'(wv));
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        chk("b2b_count", n_ack, 16);
        @(posedge clk); #1;
        chk("b2b_tail", 32'(ack[k]), 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        logic        w;
        logic [1:0]  s;
        logic [14:0] a;
        for (int k = 0; k < 4; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            sel[k] = '0; adr[k] = '0; wdat[k] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("reset_ack", 32'(ack[k]), 32'd0);
            chk("reset_dat", 32'(rdat[k]), 32'd0);
        end

        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 64; i++)
                xfer(k, 1'b1, 2'b11, 15'(i), 16'($urandom), rd);

        xfer(0, 1'b1, 2'b11, 15'h0005, 16'hBEEF, rd);
        xfer(0, 1'b0, 2'b11, 15'h0005, 16'h0000, rd);
        chk("word_rw", 32'(rd), 32'h0000BEEF);

        xfer(0, 1'b1, 2'b11, 15'h0010, 16'h1234, rd);
        xfer(0, 1'b1, 2'b10, 15'h0010, 16'hAB00, rd);
        xfer(0, 1'b0, 2'b11, 15'h0010, 16'h0000, rd);
        chk("lane_merge", 32'(rd), 32'h0000AB34);
        xfer(0, 1'b0, 2'b01, 15'h0010, 16'h0000, rd);
        chk("lane_low", 32'(rd), 32'h00000034);

        xfer(0, 1'b1, 2'b11, 15'h0400, 16'hFFFF, rd);
        xfer(0, 1'b0, 2'b11, 15'h0400, 16'h0000, rd);
        chk("oor_read", 32'(rd), 32'h00000000);
        xfer(0, 1'b0, 2'b11, 15'h0000, 16'h0000, rd);

        for (int k = 1; k < 4; k++) begin
            xfer(k, 1'b1, 2'b11, 15'h0007, 16'hC3A5, rd);
            xfer(k, 1'b0, 2'b11, 15'h0007, 16'h0000, rd);
            chk("sweep_rd", 32'(rd), 32'h0000C3A5);
        end

        xfer(2, 1'b1, 2'b11, 15'h0020, 16'h1357, rd);
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 2'b11; adr[2] = 15'h0020; wdat[2] = 16'h5555;
        repeat (2) @(posedge clk);
        #1;
        cyc[2] = 1'b0; stb[2] = 1'b0;
        watch_no_ack(2, 8, "abort_noack");
        xfer(2, 1'b0, 2'b11, 15'h0020, 16'h0000, rd);
        chk("abort_keep", 32'(rd), 32'h00001357);

        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 2'b11; adr[2] = 15'h0020; wdat[2] = 16'h5555;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; cyc[2] = 1'b0; stb[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ack", 32'(ack[2]), 32'd0);
        chk("midrst_dat", 32'(rdat[2]), 32'd0);
        watch_no_ack(2, 6, "midrst_noack");
        xfer(2, 1'b0, 2'b11, 15'h0020, 16'h0000, rd);
        chk("midrst_keep", 32'(rd), 32'h00001357);

        @(negedge clk);
        rst = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 2'b11; adr[1] = 15'h0030; wdat[1] = 16'hDEAD;
        @(posedge clk); #1;
        chk("rst_prio_ack", 32'(ack[1]), 32'd0);
        rst = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
        xfer(1, 1'b0, 2'b11, 15'h0030, 16'h0000, rd);

        for (int k = 0; k < 4; k++) b2b(k);

        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 30; n++) begin
                w = 1'($urandom);
                s = 2'($urandom);
                if ($urandom_range(0, 9) == 0) a = 15'($urandom_range(1024, 32767));
                else                           a = 15'($urandom_range(0, 63));
                xfer(k, w, s, a, 16'($urandom), rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_byte_ram_slave.md
Name: wb_byte_ram_slave

Overview:
- Wishbone-style single-port RAM slave on the data bus, directly downstream of the memory controller unit.
- Consumes the controller's transfer cycles (cyc/stb/we/sel/adr/dat) and returns read data plus a one-cycle ack.
- Supports per-byte-lane writes and a programmable number of wait states, so the controller's stall path is exercised.
- Out-of-range accesses complete harmlessly, so the bus never hangs.

Parameters:
- WORD, 16, data width in bits; must be even.
- DEPTH_LOG2, 10, RAM holds 2^DEPTH_LOG2 words.
- WAIT_STATES, 1, extra cycles inserted before ack; 0..15.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cyc_i  in  1  bus cycle active.
- stb_i  in  1  transfer strobe; a request is cyc_i & stb_i.
- we_i  in  1  1 = write, 0 = read.
- sel_i  in  2  byte-lane select; bit0 = dat[WORD/2-1:0], bit1 = dat[WORD-1:WORD/2].
- adr_i  in  WORD-(WORD/8)+1  word address.
- dat_i  in  WORD  write data.
- dat_o  out  WORD  read data; valid only while ack_o=1.
- ack_o  out  1  transfer complete, asserted for exactly one cycle.

Behaviour:
- Reset (rst_i=1 at an edge):
  - state <= IDLE, ack_o <= 0, dat_o <= 0, wait counter <= 0.
  - RAM contents are not cleared. Simulation initial contents are all 0.
  - A pending write is discarded.
- State machine, registered:
  - IDLE:
    - On a request (cyc_i & stb_i), latch adr_i, we_i, sel_i and dat_i.
    - If WAIT_STATES=0, go to ACK; otherwise load counter = WAIT_STATES-1 and go to WAIT.
  - WAIT:
    - If cyc_i=0, abort: go to IDLE, no write, no ack.
    - Else if counter=0, go to ACK; else decrement the counter.
  - ACK:
    - ack_o=1 for this cycle only, then go to IDLE unconditionally.
- Memory access timing:
  - Memory access happens on the edge that enters ACK, using the latched request.
  - Write: update only the lanes with sel=1; other lanes keep their old value.
  - Read: dat_o <= the RAM word, with lanes where sel=0 forced to 0.
  - dat_o holds its last value outside ACK.
- Latency: request first sampled at edge E; ack_o is high in the cycle after edge E+WAIT_STATES. WAIT_STATES=0 gives ack in the cycle immediately after the request edge.
- Inputs are sampled only in IDLE. Changes to adr/dat/sel/we during WAIT or ACK are ignored.
- sel_i=00: the access completes and is acked; a write changes nothing and a read returns 0.
- Out-of-range (any adr_i bit at or above DEPTH_LOG2 set): acked normally; writes are dropped and reads return 0.
- Back-to-back: after ACK the slave is always in IDLE for at least one cycle. A request still present in that IDLE cycle is treated as a new transfer. Minimum spacing between two acks is WAIT_STATES+2 cycles.
- Read-after-write to the same address in the next transfer returns the newly written lanes.
- rst_i takes priority over any request arriving at the same edge.
- ack_o is never asserted when cyc_i was low at the edge entering ACK. An abort on that edge wins over ack.

Test Plan:
- Word write/read, WAIT_STATES=1:
  - Write 0xBEEF to address 0x0005, sel=11, then read with sel=11.
  - Required: dat_o=0xBEEF. Each ack arrives in the cycle after edge E+1 and lasts 1 cycle.
- Byte-lane merge:
  - Preload 0x1234 at address 0x0010.
  - Write 0xAB00 with sel=10, then read with sel=11: required 0xAB34.
  - Read with sel=01: required 0x0034.
- Wait-state sweep:
  - Run WAIT_STATES=0, 3 and 15; count cycles from request edge to ack.
  - Required: 1, 4 and 16 cycles; ack width exactly 1 cycle each time.
- Out of range, DEPTH_LOG2=10:
  - Write 0xFFFF to address 0x0400 (acked), then read 0x0400 (acked).
  - Required: read returns 0x0000 and address 0x0000 is unchanged.
- Abort and reset:
  - With WAIT_STATES=3, write 0x5555 to address 0x0020 and drop cyc_i after 1 wait cycle. Required: no ack, and a later read returns the prior value.
  - Repeat with rst_i pulsed mid-WAIT. Required: ack_o=0, dat_o=0, and the next request is handled normally.
- Back-to-back from the memory controller unit:
  - Drive alternating write/read commands at addresses 0x0001..0x0008.
  - Required: every read returns the data just written, no missed or duplicate acks, and the acks are spaced at least WAIT_STATES+2 cycles apart.
